// File: rtl/rdyacpt_pkg.sv
// Shared types and LFSR helpers for the rdy/acpt stream source.
//   state_e    : burst FSM states (IDLE/SEND/GAP/DONE)
//   lfsr_taps  : Galois tap mask for a maximal-length LFSR of the given width
//   lfsr_next  : one Galois (right-shift) LFSR step
package rdyacpt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned LFSR_MAX_W = 32;

  // Tap masks are tabulated for widths 2..16 and 32; other widths fall back
  // to the 32-bit polynomial truncated by the caller and are not maximal.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned width);
    logic [LFSR_MAX_W-1:0] taps;
    case (width)
      2:       taps = 32'h0000_0003;
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0E08;
      13:      taps = 32'h0000_1C80;
      14:      taps = 32'h0000_3802;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_B400;
      default: taps = 32'h8020_0003;
    endcase
    return taps;
  endfunction

  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] cur,
                                                      input int unsigned        width);
    logic [LFSR_MAX_W-1:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ lfsr_taps(width);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rdyacpt_src_datagen.sv
// Data word generator for rdyacpt_source: holds the current word, loads the
// seed and advances to the next word on request.
// Build option: `RDYACPT_SOURCE_LFSR_EN selects a Galois LFSR sequence (a zero
// seed is replaced by 1); otherwise the word increments with silent wrap.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (word clears to 0)
//   load_i      : capture seed_i as the current word
//   step_i      : advance to the next word (ignored when load_i is high)
//   seed_i      : first word of a burst
//   data_o      : current word (registered)
module rdyacpt_src_datagen
  import rdyacpt_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

`ifdef RDYACPT_SOURCE_LFSR_EN
  logic [LFSR_MAX_W-1:0] step_ext;

  // LFSR next word; the all-zero state would lock up, so a zero seed becomes 1.
  always_comb begin
    step_ext = LFSR_MAX_W'(data_q);
    data_d   = data_q;
    if (load_i) begin
      data_d = (seed_i == '0) ? WIDTH'(1) : seed_i;
    end else if (step_i) begin
      data_d = WIDTH'(lfsr_next(step_ext, WIDTH));
    end
  end
`else
  // Incrementing next word, wrapping modulo 2^WIDTH.
  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = seed_i;
    end else if (step_i) begin
      data_d = data_q + WIDTH'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/rdyacpt_source.sv
// Burst traffic source for a rdy/acpt pipeline: emits num_words words starting
// at seed, with gap_cycles idle cycles between words, and reports progress.
// Build option: `RDYACPT_SOURCE_LFSR_EN switches the data sequence from
// incrementing to LFSR (see rdyacpt_src_datagen).
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   start            : burst request, sampled only in IDLE
//   num_words        : burst length (captured with start)
//   gap_cycles       : idle cycles between words (captured with start)
//   seed             : first data word (captured with start)
//   downstream_rdy   : word valid toward sink
//   downstream_acpt  : sink accepts; transfer = rdy & acpt at a rising edge
//   downstream_data  : current word
//   busy             : burst in progress
//   done             : one-cycle end-of-burst pulse
//   words_sent       : transfers completed in the current/last burst
module rdyacpt_source
  import rdyacpt_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned GAP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic [WIDTH-1:0] seed,
  output logic             downstream_rdy,
  input  logic             downstream_acpt,
  output logic [WIDTH-1:0] downstream_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_sent
);

  state_e           state_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] sent_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             rdy_q;
  logic             busy_q;
  logic             done_q;

  logic             accept_c;
  logic             xfer_c;
  logic             last_c;
  logic             step_c;

  assign accept_c = (state_q == ST_IDLE) && start;
  assign xfer_c   = (state_q == ST_SEND) && rdy_q && downstream_acpt;
  // sent_q < num_q whenever this matters, so the increment cannot overflow.
  assign last_c   = ((sent_q + CNT_W'(1)) == num_q);
  // The word only advances when another word follows; the last word is held.
  assign step_c   = xfer_c && !last_c;

  rdyacpt_src_datagen #(
    .WIDTH (WIDTH)
  ) u_datagen (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept_c),
    .step_i (step_c),
    .seed_i (seed),
    .data_o (downstream_data)
  );

  // Burst FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      num_q     <= '0;
      sent_q    <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            num_q  <= num_words;
            gap_q  <= gap_cycles;
            sent_q <= '0;
            busy_q <= 1'b1;
            if (num_words == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_SEND;
              rdy_q   <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (xfer_c) begin
            sent_q <= sent_q + CNT_W'(1);
            if (last_c) begin
              rdy_q   <= 1'b0;
              state_q <= ST_DONE;
            end else if (gap_q != '0) begin
              // One gap cycle elapses while entering GAP, hence the -1.
              rdy_q     <= 1'b0;
              gap_cnt_q <= gap_q - GAP_W'(1);
              state_q   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            rdy_q   <= 1'b1;
            state_q <= ST_SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign downstream_rdy = rdy_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign words_sent     = sent_q;

endmodule

// File: tb/tb_rdyacpt_source.sv
// Self-checking bench for rdyacpt_source: a transaction-level model predicts
// rdy/busy/done/words_sent/data every cycle, plus directed literal checks.
module tb_rdyacpt_source;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned GAP_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_words;
  logic [GAP_W-1:0] gap_cycles;
  logic [WIDTH-1:0] seed;
  logic             acpt;
  logic             rdy;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] words_sent;

  always #5 clk = ~clk;

  rdyacpt_source #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .GAP_W (GAP_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .num_words       (num_words),
    .gap_cycles      (gap_cycles),
    .seed            (seed),
    .downstream_rdy  (rdy),
    .downstream_acpt (acpt),
    .downstream_data (data),
    .busy            (busy),
    .done            (done),
    .words_sent      (words_sent)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [WIDTH-1:0] obs_data[$];
  bit               rdy_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference data sequence.
  function automatic logic [WIDTH-1:0] first_word(input logic [WIDTH-1:0] s);
`ifdef RDYACPT_SOURCE_LFSR_EN
    return (s == 0) ? WIDTH'(1) : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] v);
`ifdef RDYACPT_SOURCE_LFSR_EN
    logic [WIDTH-1:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ WIDTH'(8'hB8);
    return s;
`else
    return WIDTH'(v + 1);
`endif
  endfunction

  // Model: expected outputs for the next sampling point.
  bit               m_rdy, m_busy, m_done, m_fin;
  logic [WIDTH-1:0] m_data;
  int               m_sent, m_left, m_wait, m_gap;

  initial begin
    m_rdy = 0; m_busy = 0; m_done = 0; m_fin = 0;
    m_data = '0; m_sent = 0; m_left = 0; m_wait = 0; m_gap = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("rdy", 32'(rdy), 32'(m_rdy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("words_sent", 32'(words_sent), 32'(m_sent));
        if (m_rdy) chk("data", 32'(data), 32'(m_data));
      end
      rdy_log.push_back(rdy);
      if (rdy && acpt) obs_data.push_back(data);
      if (reset) begin
        m_rdy = 0; m_busy = 0; m_done = 0; m_fin = 0;
        m_data = '0; m_sent = 0; m_left = 0; m_wait = 0;
      end else begin
        m_done = 0;
        if (!m_busy) begin
          if (start) begin
            m_busy = 1; m_sent = 0; m_gap = int'(gap_cycles); m_left = int'(num_words);
            if (num_words == 0) m_fin = 1;
            else begin m_rdy = 1; m_data = first_word(seed); end
          end
        end else if (m_fin) begin
          m_busy = 0; m_done = 1; m_fin = 0;
        end else if (m_rdy) begin
          if (acpt) begin
            m_sent++; m_left--;
            if (m_left == 0) begin
              m_rdy = 0; m_fin = 1;
            end else begin
              m_data = next_word(m_data);
              if (m_gap != 0) begin m_rdy = 0; m_wait = m_gap; end
            end
          end
        end else begin
          m_wait--;
          if (m_wait == 0) m_rdy = 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int n, input int g, input int s);
    num_words  = CNT_W'(n);
    gap_cycles = GAP_W'(g);
    seed       = WIDTH'(s);
    start      = 1'b1;
    cyc();
    start      = 1'b0;
  endtask

  // Drive acpt from a 4-cycle pattern until done pulses, bounded by budget.
  task automatic run(input string name, input int budget, input logic [3:0] pat);
    logic [3:0] p;
    bit seen;
    p = pat;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      acpt = p[i % 4];
      @(negedge clk);
      if (done) seen = 1;
      cyc();
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic chk_obs(input string name, input int n,
                         input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                         input logic [WIDTH-1:0] e2, input logic [WIDTH-1:0] e3);
    logic [WIDTH-1:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({name, "_count"}, 32'(obs_data.size()), 32'(n));
    for (int i = 0; i < n && i < obs_data.size(); i++) begin
      chk($sformatf("%s_word%0d", name, i), 32'(obs_data[i]), 32'(e[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] gap_pat;
    reset = 1; start = 0; acpt = 0; num_words = '0; gap_cycles = '0; seed = '0;
    repeat (3) cyc();
    reset  = 0;
    chk_en = 1;
    chk("reset_rdy", 32'(rdy), 0);
    chk("reset_data", 32'(data), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_words", 32'(words_sent), 0);

    // 1: back-to-back burst of 4
    obs_data.delete(); acpt = 1;
    launch(4, 0, 'h10);
    run("t1", 20, 4'b1111);
`ifdef RDYACPT_SOURCE_LFSR_EN
    chk_obs("t1", 4, 8'h10, 8'h08, 8'h04, 8'h02);
`else
    chk_obs("t1", 4, 8'h10, 8'h11, 8'h12, 8'h13);
`endif
    chk("t1_words_sent", 32'(words_sent), 4);

    // 2: backpressure, acpt pattern 1,0,0,1
    obs_data.delete(); acpt = 0;
    launch(3, 0, 'h00);
    run("t2", 40, 4'b1001);
`ifdef RDYACPT_SOURCE_LFSR_EN
    chk_obs("t2", 3, 8'h01, 8'hB8, 8'h5C, 8'h00);
`else
    chk_obs("t2", 3, 8'h00, 8'h01, 8'h02, 8'h00);
`endif
    chk("t2_words_sent", 32'(words_sent), 3);

    // 3: inter-word gap of 2
    acpt = 1;
    launch(3, 2, 'h40);
    rdy_log.delete();
    run("t3", 30, 4'b1111);
    gap_pat = 7'b1001001;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("t3_rdy%0d", k), 32'(rdy_log[k]), 32'(gap_pat[6-k]));
    end
    chk("t3_words_sent", 32'(words_sent), 3);

    // 4: zero-length burst
    launch(0, 0, 'h77);
    chk("t4_busy", 32'(busy), 1);
    chk("t4_rdy", 32'(rdy), 0);
    chk("t4_done0", 32'(done), 0);
    cyc();
    chk("t4_done1", 32'(done), 1);
    chk("t4_busy_off", 32'(busy), 0);
    chk("t4_words_sent", 32'(words_sent), 0);
    cyc();
    chk("t4_done_end", 32'(done), 0);

    // 5: data wrap, start mid-burst ignored
    obs_data.delete(); acpt = 1;
    launch(4, 0, 'hFE);
    num_words = CNT_W'(9); seed = 8'h55; start = 1;
    cyc();
    start = 0;
    run("t5", 20, 4'b1111);
`ifdef RDYACPT_SOURCE_LFSR_EN
    chk_obs("t5", 4, 8'hFE, 8'h7F, 8'h87, 8'hFB);
`else
    chk_obs("t5", 4, 8'hFE, 8'hFF, 8'h00, 8'h01);
`endif
    chk("t5_words_sent", 32'(words_sent), 4);
    repeat (3) cyc();
    chk("t5_no_relaunch", 32'(rdy), 0);

    // 6: reset while rdy=1 and acpt=0, then a fresh burst
    acpt = 0;
    launch(5, 0, 'h33);
    cyc();
    chk("t6_rdy_held", 32'(rdy), 1);
    chk("t6_data_held", 32'(data), 32'h33);
    reset = 1;
    cyc();
    chk("t6_rst_rdy", 32'(rdy), 0);
    chk("t6_rst_data", 32'(data), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_words", 32'(words_sent), 0);
    reset = 0;
    obs_data.delete();
    launch(2, 0, 'h00);
    run("t6", 20, 4'b1111);
`ifdef RDYACPT_SOURCE_LFSR_EN
    chk_obs("t6", 2, 8'h01, 8'hB8, 8'h00, 8'h00);
`else
    chk_obs("t6", 2, 8'h00, 8'h01, 8'h00, 8'h00);
`endif
    chk("t6_words_sent", 32'(words_sent), 2);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
